// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller.
// Latency: n/a (types, constants and a pure helper only).
// Backpressure: n/a.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Access size codes carried in sign_mask[2:0]; sign_mask[3] selects sign extension.
    localparam logic [2:0] SZ_BYTE = 3'b001;
    localparam logic [2:0] SZ_HALF = 3'b011;
    localparam logic [2:0] SZ_WORD = 3'b111;

    localparam logic [31:0] DEF_ADDR_BASE = 32'h0000_1000;
    localparam logic [31:0] DEF_LED_ADDR  = 32'h0000_2000;

    // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [2:0] size);
        return ((size == SZ_HALF) && addr_lo[0]) ||
               ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane extract/extend for loads and lane merge for sub-word stores.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
// Ports: word (RAM/LED word), addr_lo (byte offset), sign_mask ({sign,size}),
//        write_data (right-aligned store data) -> load_data, merged_word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  sign_mask,
    input  logic [31:0] write_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic       sign;
    logic [7:0] byte_v;
    logic [15:0] half_v;

    assign sign = sign_mask[3];

    always_comb begin
        load_data   = word;
        merged_word = write_data;
        byte_v      = word[{addr_lo, 3'b000} +: 8];
        half_v      = word[{addr_lo[1], 4'b0000} +: 16];
        case (sign_mask[2:0])
            SZ_BYTE: begin
                load_data   = {{24{sign & byte_v[7]}}, byte_v};
                merged_word = word;
                merged_word[{addr_lo, 3'b000} +: 8] = write_data[7:0];
            end
            SZ_HALF: begin
                load_data   = {{16{sign & half_v[15]}}, half_v};
                merged_word = word;
                merged_word[{addr_lo[1], 4'b0000} +: 16] = write_data[15:0];
            end
            default: begin
                // Word (and any unused size code) moves the full 32 bits.
                load_data   = word;
                merged_word = write_data;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// RV32I data-memory controller: sub-word RMW on a sync-read word RAM plus an 8-bit LED register.
// Latency: request seen in cycle N, busy in N and N+1, DONE (busy low, read_data valid) in N+2.
// Backpressure: busy stalls the core while an access is in flight; request inputs ignored in DONE.
// Ports: clk, reset (sync, active-high); addr/write_data/memwrite/memread/sign_mask from MEM stage;
//        read_data (extended load result), busy (stall), led (LED register), misalign (sticky flag).
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE   = DEF_ADDR_BASE,
    parameter logic [31:0] LED_ADDR    = DEF_LED_ADDR
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  sign_mask,
    output logic [31:0] read_data,
    output logic        busy,
    output logic [7:0]  led,
    output logic        misalign
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

    state_t      state, state_nxt;
    logic        req;

    // Request captured in IDLE; the core may change its inputs afterwards.
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  sm_q;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] ram_q;
    logic [IDX_W-1:0] rd_idx, wr_idx;

    logic        in_ram, hit_led, mis;
    logic        ram_we, led_we;
    logic [31:0] src_word, load_data, merged_word;

    assign req = memread | memwrite;

    // ADDR_BASE is aligned to the RAM size, so the low address bits index the RAM directly.
    assign rd_idx = addr[IDX_W+1:2];
    assign wr_idx = addr_q[IDX_W+1:2];

    assign in_ram  = (addr_q >= ADDR_BASE) && (addr_q < ADDR_BASE + RAM_BYTES);
    assign hit_led = (addr_q == LED_ADDR);
    assign mis     = is_misaligned(addr_q[1:0], sm_q[2:0]);

    // LED loads go through the same extract/extend path as RAM loads.
    assign src_word = hit_led ? {24'b0, led} : ram_q;

    dmem_lane_align u_align (
        .word        (src_word),
        .addr_lo     (addr_q[1:0]),
        .sign_mask   (sm_q),
        .write_data  (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        ram_we    = 1'b0;
        led_we    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    busy      = 1'b1;
                    state_nxt = memwrite ? WRITE : READ;
                end
            end
            READ: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            WRITE: begin
                busy      = 1'b1;
                state_nxt = DONE;
                // Reset in this cycle must leave the RAM untouched.
                ram_we    = !reset && !mis && in_ram;
                led_we    = !mis && hit_led;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            read_data <= 32'b0;
            led       <= 8'b0;
            misalign  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == READ) begin
                read_data <= (mis || !(in_ram || hit_led)) ? 32'b0 : load_data;
            end
            if (((state == READ) || (state == WRITE)) && mis) begin
                misalign <= 1'b1;
            end
            if (led_we) begin
                led <= wdata_q[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            addr_q  <= addr;
            wdata_q <= write_data;
            sm_q    <= sign_mask;
        end
    end

    // Synchronous-read RAM: the word addressed in IDLE is ready in READ/WRITE.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[wr_idx] <= merged_word;
        end
        ram_q <= mem[rd_idx];
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus randomized accesses
// compared every cycle against a word-array model of RAM, LED and misalign state.
module tb_data_mem_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, write_data;
    logic        memwrite, memread;
    logic [3:0]  sign_mask;
    logic [31:0] read_data;
    logic        busy;
    logic [7:0]  led;
    logic        misalign;

    data_mem_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .write_data (write_data),
        .memwrite   (memwrite),
        .memread    (memread),
        .sign_mask  (sign_mask),
        .read_data  (read_data),
        .busy       (busy),
        .led        (led),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state / expected outputs.
    logic [31:0] mem_m [16];
    logic [31:0] exp_rd;
    logic        exp_busy;
    logic [7:0]  exp_led;
    logic        exp_mis;
    logic        chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",      32'(busy),     32'(exp_busy));
            chk("led",       32'(led),      32'(exp_led));
            chk("misalign",  32'(misalign), 32'(exp_mis));
            chk("read_data", read_data,     exp_rd);
        end
    end

    function automatic logic m_misal(input logic [31:0] a, input logic [3:0] sm);
        if (sm[2:0] == 3'b011) return a[0];
        if (sm[2:0] == 3'b111) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [31:0] a, input logic [3:0] sm);
        logic [31:0] v;
        int sh;
        v = w;
        if (sm[2:0] == 3'b001) begin
            sh = int'(a[1:0]) * 8;
            v  = (w >> sh) & 32'hFF;
            if (sm[3] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sm[2:0] == 3'b011) begin
            sh = int'(a[1]) * 16;
            v  = (w >> sh) & 32'hFFFF;
            if (sm[3] && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] a,
                                            input logic [3:0] sm, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (sm[2:0] == 3'b001) begin
            sh   = int'(a[1:0]) * 8;
            mask = 32'hFF << sh;
            return (w & ~mask) | ((wd & 32'hFF) << sh);
        end
        if (sm[2:0] == 3'b011) begin
            sh   = int'(a[1]) * 16;
            mask = 32'hFFFF << sh;
            return (w & ~mask) | ((wd & 32'hFFFF) << sh);
        end
        return wd;
    endfunction

    task automatic model_apply(input logic wr, input logic rd, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] sm);
        logic mis, in_ram, is_led;
        logic [31:0] off;
        int idx;
        mis    = m_misal(a, sm);
        in_ram = (a >= 32'h1000) && (a < 32'h2000);
        is_led = (a == 32'h2000);
        off    = (a - 32'h1000) >> 2;
        idx    = int'(off[3:0]);
        if (mis) exp_mis = 1'b1;
        if (wr) begin
            if (!mis) begin
                if (in_ram)      mem_m[idx] = m_merge(mem_m[idx], a, sm, wd);
                else if (is_led) exp_led    = wd[7:0];
            end
        end else if (rd) begin
            if (mis)         exp_rd = 32'h0;
            else if (in_ram) exp_rd = m_ext(mem_m[idx], a, sm);
            else if (is_led) exp_rd = m_ext({24'h0, exp_led}, a, sm);
            else             exp_rd = 32'h0;
        end
    endtask

    // One full access; returns 1ns after the edge that enters DONE.
    task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] sm, input logic junk);
        @(posedge clk); #1;
        memwrite = wr; memread = rd; addr = a; write_data = wd; sign_mask = sm;
        exp_busy = 1'b1;
        @(posedge clk); #1;
        memwrite = 1'b0; memread = 1'b0;
        addr = $urandom; write_data = $urandom; sign_mask = 4'($urandom);
        exp_busy = 1'b1;
        @(posedge clk); #1;
        model_apply(wr, rd, a, wd, sm);
        exp_busy = 1'b0;
        if (junk) begin
            memread = 1'b1; memwrite = 1'($urandom); addr = 32'h1000;
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        memwrite = 1'b0; memread = 1'b0;
        exp_busy = 1'b0;
    endtask

    logic [2:0] sz_tab [3];

    initial begin
        logic [31:0] a;
        logic [3:0]  sm;
        int r, k;
        sz_tab = '{SZ_BYTE, SZ_HALF, SZ_WORD};

        reset = 1'b1; memwrite = 1'b0; memread = 1'b0;
        addr = 32'h0; write_data = 32'h0; sign_mask = 4'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_rd = 32'h0; exp_busy = 1'b0; exp_led = 8'h0; exp_mis = 1'b0;
        chk_en = 1'b1;
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_misalign", 32'(misalign), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        for (int i = 0; i < 16; i++)
            access(1'b1, 1'b0, 32'h1000 + 32'(4 * i), $urandom, 4'b0111, 1'b0);

        // Word store/load.
        access(1'b1, 1'b0, 32'h1004, 32'hDEAD_BEEF, 4'b0111, 1'b0);
        access(1'b0, 1'b1, 32'h1004, 32'h0, 4'b0111, 1'b0);
        chk("word_load", read_data, 32'hDEAD_BEEF);

        // Sub-word read-modify-write and extension.
        access(1'b1, 1'b0, 32'h1008, 32'h1122_3344, 4'b0111, 1'b0);
        access(1'b1, 1'b0, 32'h100A, 32'h0000_00AA, 4'b0001, 1'b1);
        access(1'b0, 1'b1, 32'h1008, 32'h0, 4'b0111, 1'b0);
        chk("rmw_word", read_data, 32'h11AA_3344);
        access(1'b0, 1'b1, 32'h100A, 32'h0, 4'b1001, 1'b0);
        chk("signed_byte", read_data, 32'hFFFF_FFAA);
        access(1'b0, 1'b1, 32'h100A, 32'h0, 4'b0011, 1'b0);
        chk("unsigned_half", read_data, 32'h0000_11AA);

        // Out-of-range load and dual request.
        access(1'b0, 1'b1, 32'h0000_0FFC, 32'h0, 4'b0111, 1'b0);
        chk("oor_load", read_data, 32'h0);
        chk("oor_misalign", 32'(misalign), 32'h0);
        access(1'b1, 1'b1, 32'h1000, 32'h77, 4'b0111, 1'b0);
        access(1'b0, 1'b1, 32'h1000, 32'h0, 4'b0111, 1'b0);
        chk("dual_req", read_data, 32'h77);

        // LED register.
        access(1'b1, 1'b0, 32'h2000, 32'h5A, 4'b0001, 1'b0);
        chk("led_write", 32'(led), 32'h5A);
        access(1'b0, 1'b1, 32'h2000, 32'h0, 4'b1001, 1'b0);
        chk("led_load", read_data, 32'h0000_005A);
        access(1'b1, 1'b0, 32'h2000, 32'hF0, 4'b0001, 1'b0);
        access(1'b0, 1'b1, 32'h2000, 32'h0, 4'b1001, 1'b0);
        chk("led_load_neg", read_data, 32'hFFFF_FFF0);

        // Misaligned store: no write, sticky flag.
        access(1'b1, 1'b0, 32'h1006, 32'h55, 4'b0111, 1'b0);
        chk("mis_set", 32'(misalign), 32'h1);
        access(1'b0, 1'b1, 32'h1004, 32'h0, 4'b0111, 1'b0);
        chk("mis_no_write", read_data, 32'hDEAD_BEEF);
        access(1'b0, 1'b1, 32'h1008, 32'h0, 4'b0111, 1'b0);
        access(1'b1, 1'b0, 32'h1010, 32'h1234, 4'b0011, 1'b0);
        chk("mis_sticky", 32'(misalign), 32'h1);

        // Reset during WRITE.
        access(1'b1, 1'b0, 32'h100C, 32'h600D_CAFE, 4'b0111, 1'b0);
        @(posedge clk); #1;
        memwrite = 1'b1; memread = 1'b0; addr = 32'h100C;
        write_data = 32'hCAFE_F00D; sign_mask = 4'b0111;
        exp_busy = 1'b1;
        @(posedge clk); #1;
        memwrite = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_busy = 1'b0; exp_led = 8'h0; exp_rd = 32'h0; exp_mis = 1'b0;
        chk("rstw_led", 32'(led), 32'h0);
        chk("rstw_read_data", read_data, 32'h0);
        chk("rstw_busy", 32'(busy), 32'h0);
        access(1'b0, 1'b1, 32'h100C, 32'h0, 4'b0111, 1'b0);
        chk("rstw_no_write", read_data, 32'h600D_CAFE);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8)       a = 32'h1000 + 32'($urandom_range(0, 63));
            else if (r == 8) a = 32'h2000;
            else if (($urandom % 2) == 0) a = 32'h0FF0 + 32'($urandom_range(0, 15));
            else             a = 32'h2001 + 32'($urandom_range(0, 15));
            sm = {1'($urandom), sz_tab[$urandom_range(0, 2)]};
            k  = int'($urandom_range(0, 4));
            access(k == 2 || k == 3 || k == 4, k == 0 || k == 1 || k == 4,
                   a, $urandom, sm, 1'($urandom));
        end

        idle_cycle();
        idle_cycle();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Data-memory controller directly downstream of the 5-stage RV32I core's MEM stage.
- Consumes the core's memory request: address, store data, memwrite, memread and sign_mask.
- Performs byte/halfword/word access on a 32-bit-wide synchronous-read word RAM, using read-modify-write for sub-word stores.
- Returns aligned, sign- or zero-extended load data, and stalls the core with busy while an access is in flight.
- Also hosts the memory-mapped 8-bit debug LED register.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit RAM words (power of two).
- ADDR_BASE, 32'h0000_1000, byte address of RAM word 0.
- LED_ADDR, 32'h0000_2000, byte address of the LED register.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  byte address from the core's EX/MEM ALU result.
- write_data  in  32  store data, right-aligned.
- memwrite  in  1  store request.
- memread  in  1  load request.
- sign_mask  in  4  {sign, size[2:0]}; size 3'b001 = byte, 3'b011 = half, 3'b111 = word; sign=1 sign-extends loads.
- read_data  out  32  extended load result.
- busy  out  1  stall request to the core.
- led  out  8  LED register.
- misalign  out  1  sticky misaligned-access flag.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. It is sampled on the clk rising edge and has priority over every other event.
- Reset values: state=IDLE, read_data=0, led=0, misalign=0, busy=0 (combinational, reflects IDLE with no request). RAM contents are not cleared.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - req = memread | memwrite.
  - On req: latch addr, write_data, sign_mask and the op; drive RAM read address addr[log2(DEPTH_WORDS)+1:2].
  - memwrite has priority over memread when both are set.
  - Next state is WRITE for a store, READ for a load.
- busy = (state==IDLE & req) | state==READ | state==WRITE. busy is low in DONE, and the core advances at the end of DONE.
- READ:
  - RAM word is available.
  - Extract lane: byte at addr[1:0]; half at addr[1].
  - Extend per sign.
  - Register into read_data at the end of this cycle. Next state is DONE.
- WRITE:
  - RAM word is available.
  - Merge write_data lanes into the word: byte lane addr[1:0], half lane addr[1], word replaces all.
  - Write the RAM this cycle. Next state is DONE.
- DONE: request inputs are ignored for this cycle. Next state is IDLE. read_data holds until the next load completes.
- Latency: request seen in cycle N; busy is high in N and N+1; DONE in N+2 with read_data valid.
- Misaligned accesses (half with addr[0]=1; word with addr[1:0]!=0):
  - No RAM or LED write.
  - Load result is 0.
  - misalign set to 1; it stays set until reset.
  - Timing is unchanged.
- Out-of-range addresses (not in [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS) and not LED_ADDR): loads return 0, stores are dropped. misalign is not affected.
- LED register:
  - A store of any size to LED_ADDR writes led=write_data[7:0] in WRITE.
  - A load of LED_ADDR returns {24'b0, led}, extended per sign_mask.
- Reset mid-operation: reset sampled during WRITE suppresses that RAM write; state returns to IDLE.
- Sign extension: byte sign extends from bit 7, half from bit 15; sign=0 zero-extends.

Decomposition:
- Shared package dmem_pkg:
  - state encoding (IDLE=2'd0, READ=2'd1, WRITE=2'd2, DONE=2'd3).
  - size constants SZ_BYTE=3'b001, SZ_HALF=3'b011, SZ_WORD=3'b111.
  - default ADDR_BASE and LED_ADDR.
- Sub-module dmem_lane_align: combinational extract/extend and merge from (word, addr[1:0], sign_mask, write_data).
- The RAM array is inferred inside data_mem_ctrl.

Test Plan:
- Word store/load: reset; store 32'hDEADBEEF at 0x1004 (size WORD); load word 0x1004 -> busy high for 2 cycles each access; read_data=32'hDEADBEEF in DONE.
- Sub-word RMW: word 0x1008=32'h11223344; store byte 8'hAA at 0x100A; then load word -> 32'h11AA3344. Load signed byte 0x100A -> 32'hFFFFFFAA. Load unsigned half 0x100A -> 32'h000011AA.
- Misaligned store: store word 32'h55 at 0x1006 -> RAM unchanged (load 0x1004 returns prior value); misalign=1 and stays 1 through three further legal accesses.
- LED: store byte 8'h5A to 0x2000 -> led=8'h5A after WRITE. Load signed byte 0x2000 -> 32'h0000005A. Store 8'hF0, load signed byte -> 32'hFFFFFFF0.
- Out-of-range and dual request: load 0x0000_0FFC -> read_data=0, misalign stays 0. memread=memwrite=1, store 32'h77 to 0x1000 -> treated as store; subsequent load returns 32'h77.
- Reset mid-write: issue store 32'hCAFEF00D to 0x100C; assert reset in the WRITE cycle -> state IDLE, led=0, read_data=0; load 0x100C returns the pre-store value.
